// File: rtl/ppl_pkg.sv
`default_nettype none
// ==========================================================================
// ppl_pkg : shared types and constants for the pipeline memory arbiter
// Rev 1.0
// ==========================================================================
package ppl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_M  = 2'd1,
      ST_BUSY_IF = 2'd2,
      ST_DONE    = 2'd3
   } arb_state_t;

   localparam int TIMEOUT_DEFAULT = 255;
   localparam int CNT_W           = 8;

endpackage
`default_nettype wire

// File: rtl/ppl_timeout_cnt.sv
`default_nettype none
// ==========================================================================
// ppl_timeout_cnt : 8-bit bus-wait counter, flags expiry at TIMEOUT
// Rev 1.0
// ==========================================================================
module ppl_timeout_cnt
   import ppl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = (cnt_q == CNT_W'(TIMEOUT));

   // Saturates at TIMEOUT so a stuck requester can never wrap the count
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ppl_mem_arb.sv
`default_nettype none
// ==========================================================================
// ppl_mem_arb : single-port memory bus arbiter between IF and MEM stages
// Rev 1.0
// ==========================================================================
module ppl_mem_arb
   import ppl_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_stall,
   input  logic          m_read,
   input  logic          m_write,
   input  logic [AW-1:0] m_addr,
   input  logic [DW-1:0] m_wdata,
   output logic [DW-1:0] m_rdata,
   output logic          m_stall,
   output logic          bus_req,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ack,
   output logic          bus_err
);

   arb_state_t    state_q, state_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] m_rdata_q, m_rdata_d;
   logic          bus_err_q, bus_err_d;
   logic          m_done_q, m_done_d;
   logic          if_done_q, if_done_d;

   logic          m_req;
   logic          m_stall_int;
   logic          if_stall_int;
   logic          busy;
   logic          complete;
   logic          tmo_expired;

   ppl_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .reset   (reset),
      .clear   (!busy),
      .enable  (busy),
      .expired (tmo_expired)
   );

   always_comb begin
      m_req        = m_read | m_write;
      m_stall_int  = m_req & ~m_done_q;
      if_stall_int = m_stall_int | (if_req & ~if_done_q);
      busy         = (state_q == ST_BUSY_M) || (state_q == ST_BUSY_IF);
      // A real ack in the expiry cycle still counts as a normal completion
      complete     = busy & (bus_ack | tmo_expired);

      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_rdata_d  = if_rdata_q;
      m_rdata_d   = m_rdata_q;
      bus_err_d   = bus_err_q;
      m_done_d    = m_stall_int  ? m_done_q  : 1'b0;
      if_done_d   = if_stall_int ? if_done_q : 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (m_req && !m_done_q) begin
               state_d     = ST_BUSY_M;
               bus_req_d   = 1'b1;
               bus_we_d    = m_write;
               bus_addr_d  = m_addr;
               bus_wdata_d = m_wdata;
            end else if (if_req && !if_done_q) begin
               state_d    = ST_BUSY_IF;
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_addr_d = if_addr;
            end
         end
         ST_BUSY_M: begin
            if (complete) begin
               state_d   = ST_DONE;
               bus_req_d = 1'b0;
               m_done_d  = 1'b1;
               if (!bus_we_q) begin
                  m_rdata_d = bus_ack ? bus_rdata : '0;
               end
               if (!bus_ack) begin
                  bus_err_d = 1'b1;
               end
            end
         end
         ST_BUSY_IF: begin
            if (complete) begin
               state_d    = ST_DONE;
               bus_req_d  = 1'b0;
               if_done_d  = 1'b1;
               if_rdata_d = bus_ack ? bus_rdata : '0;
               if (!bus_ack) begin
                  bus_err_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         if_rdata_q  <= '0;
         m_rdata_q   <= '0;
         bus_err_q   <= 1'b0;
         m_done_q    <= 1'b0;
         if_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_rdata_q  <= if_rdata_d;
         m_rdata_q   <= m_rdata_d;
         bus_err_q   <= bus_err_d;
         m_done_q    <= m_done_d;
         if_done_q   <= if_done_d;
      end
   end

   // Stalls are gated so that every output reads 0 while reset is held
   assign m_stall   = reset & m_stall_int;
   assign if_stall  = reset & if_stall_int;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign m_rdata   = m_rdata_q;
   assign bus_err   = bus_err_q;

endmodule
`default_nettype wire
